// File: rtl/video_packet_send_pkg.sv
// Shared link constants for the video GT packet path (send and receive sides):
// K-code words, their control flags and the packetiser state encoding.
package video_packet_send_pkg;

  localparam logic [31:0] FS_WORD   = 32'hff0000bc;
  localparam logic [31:0] LS_WORD   = 32'hff0002bc;
  localparam logic [31:0] IDLE_WORD = 32'h000000bc;
  localparam logic [3:0]  K_CTRL    = 4'b0001;
  localparam logic [3:0]  D_CTRL    = 4'b0000;

  typedef logic [15:0] pixel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_FS,
    ST_FS_WAIT,
    ST_SEND_LS,
    ST_SEND_DATA
  } state_e;

endpackage

// File: rtl/video_packet_send_if.sv
// Parallel video input bus: frame sync, pixel valid and 16-bit pixel.
interface video_packet_send_if;
  import video_packet_send_pkg::*;

  logic   vin_vs;
  logic   vin_de;
  pixel_t vin_data;

  modport master (output vin_vs, vin_de, vin_data);
  modport slave  (input  vin_vs, vin_de, vin_data);
endinterface

// File: rtl/video_packet_send_fifo.sv
// Single-clock 32-bit first-word-fall-through line buffer with word count
// and synchronous flush. DEPTH must be a power of two.
module sync_fifo_32 #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty,
  output logic [15:0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          do_wr, do_rd;

  assign full    = level[AW];
  assign empty   = (level == '0);
  assign count   = 16'(level);
  assign rd_data = mem[rd_ptr];

  // A pop frees the slot this cycle, so a push on a full buffer still lands.
  assign do_rd = rd_en & ~empty & ~flush;
  assign do_wr = wr_en & ~flush & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/video_packet_send.sv
// Video line packetiser: pairs 16-bit pixels into 32-bit words, buffers a line
// and frames it with FS/LS/IDLE K-codes for a GT transmitter.
module video_packet_send
  import video_packet_send_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 1024,
  parameter int unsigned FS_GAP     = 128
) (
  input  logic               tx_clk,
  input  logic               rst_n,
  video_packet_send_if.slave vin,
  input  logic [15:0]        vout_width,
  output logic [31:0]        gt_tx_data,
  output logic [3:0]         gt_tx_ctrl,
  output logic               overflow
);
  state_e      state, state_next;
  logic        vs_d, vs_rise;
  pixel_t      pix_lo;
  logic        have_lo;
  logic        wr_en, rd_en, fifo_full, fifo_empty;
  logic [31:0] wr_data, rd_data, data_next;
  logic [3:0]  ctrl_next;
  logic [15:0] fifo_count, cnt, cnt_next, half_width;
  logic        width_lsb_unused;

  assign vs_rise          = vin.vin_vs & ~vs_d;
  assign half_width       = {1'b0, vout_width[15:1]};
  assign width_lsb_unused = vout_width[0];

  // A held low pixel is always flushed next cycle: paired if de is still high,
  // zero-padded if de fell.
  assign wr_en   = have_lo & ~vs_rise;
  assign wr_data = vin.vin_de ? {vin.vin_data, pix_lo} : {16'h0000, pix_lo};

  sync_fifo_32 #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (tx_clk),
    .rst_n   (rst_n),
    .flush   (vs_rise),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d     <= 1'b0;
      pix_lo   <= '0;
      have_lo  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      vs_d <= vin.vin_vs;
      if (vs_rise) begin
        pix_lo   <= '0;
        have_lo  <= 1'b0;
        overflow <= 1'b0;
      end else begin
        if (vin.vin_de && !have_lo) begin
          pix_lo  <= vin.vin_data;
          have_lo <= 1'b1;
        end else begin
          have_lo <= 1'b0;
        end
        if (wr_en && fifo_full && !rd_en) overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE:
        if (fifo_count >= half_width) state_next = ST_SEND_LS;
      ST_SEND_FS: begin
        state_next = ST_FS_WAIT;
        cnt_next   = '0;
      end
      ST_FS_WAIT:
        if (cnt == 16'(FS_GAP - 1)) state_next = ST_IDLE;
        else                        cnt_next   = cnt + 16'd1;
      ST_SEND_LS: begin
        state_next = ST_SEND_DATA;
        cnt_next   = 16'd1;
      end
      ST_SEND_DATA:
        if (cnt == half_width) state_next = ST_IDLE;
        else                   cnt_next   = cnt + 16'd1;
      default: state_next = ST_IDLE;
    endcase
    if (vs_rise) begin
      state_next = ST_SEND_FS;
      cnt_next   = '0;
    end

    // Output word is chosen from the state being entered, so the registered
    // word always matches the current state and FWFT data leaves right after LS.
    rd_en     = (state_next == ST_SEND_DATA) && !fifo_empty;
    data_next = IDLE_WORD;
    ctrl_next = K_CTRL;
    case (state_next)
      ST_SEND_FS:   data_next = FS_WORD;
      ST_SEND_LS:   data_next = LS_WORD;
      ST_SEND_DATA: begin
        data_next = rd_data;
        ctrl_next = D_CTRL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      gt_tx_data <= IDLE_WORD;
      gt_tx_ctrl <= K_CTRL;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      gt_tx_data <= data_next;
      gt_tx_ctrl <= ctrl_next;
    end
  end

endmodule

// File: tb/tb_video_packet_send.sv
// Directed bench for video_packet_send: default instance for framing/data,
// a 16-word instance for buffer overflow.
module tb_video_packet_send;
  import video_packet_send_pkg::*;

  logic        tx_clk = 1'b0;
  logic        rst_n;
  logic [15:0] width, width16;
  logic [31:0] gt_data, gt16_data;
  logic [3:0]  gt_ctrl, gt16_ctrl;
  logic        ovf, ovf16;
  int          checks = 0;
  int          errors = 0;

  video_packet_send_if vif();
  video_packet_send_if vif16();

  video_packet_send dut (
    .tx_clk     (tx_clk),
    .rst_n      (rst_n),
    .vin        (vif),
    .vout_width (width),
    .gt_tx_data (gt_data),
    .gt_tx_ctrl (gt_ctrl),
    .overflow   (ovf)
  );

  video_packet_send #(.FIFO_DEPTH(16), .FS_GAP(4)) dut16 (
    .tx_clk     (tx_clk),
    .rst_n      (rst_n),
    .vin        (vif16),
    .vout_width (width16),
    .gt_tx_data (gt16_data),
    .gt_tx_ctrl (gt16_ctrl),
    .overflow   (ovf16)
  );

  always #5 tx_clk = ~tx_clk;

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vif.vin_vs = 1'b0;   vif.vin_de = 1'b0;   vif.vin_data = '0;
    vif16.vin_vs = 1'b0; vif16.vin_de = 1'b0; vif16.vin_data = '0;
    width = 16'd8; width16 = 16'd80;
    repeat (3) tick();
    checks++;
    if (gt_data !== IDLE_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL reset_out: got %h/%b expected %h/%b", gt_data, gt_ctrl, IDLE_WORD, K_CTRL);
    end
    checks++;
    if (ovf !== 1'b0 || ovf16 !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b/%b expected 0/0", ovf, ovf16);
    end
    checks++;
    if (dut.u_fifo.count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", dut.u_fifo.count);
    end
    @(negedge tx_clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (gt_data !== IDLE_WORD || gt_ctrl !== K_CTRL || gt16_data !== IDLE_WORD) begin
        errors++; $display("FAIL idle_after_reset[%0d]: got %h/%b expected %h/%b", i, gt_data, gt_ctrl, IDLE_WORD, K_CTRL);
      end
    end
  endtask

  task automatic test_frame_line8();
    int guard;
    logic [31:0] exp_w;
    width = 16'd8;
    vif.vin_vs = 1'b1;
    tick();
    checks++;
    if (gt_data !== FS_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL line8_fs: got %h/%b expected %h/%b", gt_data, gt_ctrl, FS_WORD, K_CTRL);
    end
    for (int i = 1; i <= 128; i++) begin
      vif.vin_de   = (i <= 8);
      vif.vin_data = (i <= 8) ? 16'(i) : 16'h0;
      tick();
      checks++;
      if (gt_data !== IDLE_WORD || gt_ctrl !== K_CTRL) begin
        errors++; $display("FAIL line8_gap[%0d]: got %h/%b expected %h/%b", i, gt_data, gt_ctrl, IDLE_WORD, K_CTRL);
      end
    end
    guard = 0;
    while (gt_data === IDLE_WORD && gt_ctrl === K_CTRL && guard < 4) begin
      tick(); guard++;
    end
    checks++;
    if (gt_data !== LS_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL line8_ls: got %h/%b expected %h/%b", gt_data, gt_ctrl, LS_WORD, K_CTRL);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_w = {16'(2*k+2), 16'(2*k+1)};
      checks++;
      if (gt_data !== exp_w || gt_ctrl !== D_CTRL) begin
        errors++; $display("FAIL line8_word[%0d]: got %h/%b expected %h/%b", k, gt_data, gt_ctrl, exp_w, D_CTRL);
      end
    end
    tick();
    checks++;
    if (gt_data !== IDLE_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL line8_tail: got %h/%b expected %h/%b", gt_data, gt_ctrl, IDLE_WORD, K_CTRL);
    end
  endtask

  task automatic test_back_to_back();
    int ls_cnt, run, widx, cyc;
    bit in_pl;
    logic [31:0] exp_w;
    vif.vin_vs = 1'b0; tick();
    width = 16'd1920;
    vif.vin_vs = 1'b1; tick();
    checks++;
    if (gt_data !== FS_WORD) begin
      errors++; $display("FAIL b2b_fs: got %h expected %h", gt_data, FS_WORD);
    end
    ls_cnt = 0; run = 0; widx = 0; cyc = 0; in_pl = 1'b0;
    while (!(ls_cnt == 2 && !in_pl) && cyc < 8000) begin
      vif.vin_de   = (cyc < 3840);
      vif.vin_data = 16'(cyc);
      tick(); cyc++;
      if (gt_ctrl === D_CTRL) begin
        exp_w = {16'(2*widx+1), 16'(2*widx)};
        checks++;
        if (!in_pl || gt_data !== exp_w) begin
          errors++; $display("FAIL b2b_word[%0d]: got %h in_line=%0d expected %h in_line=1", widx, gt_data, in_pl, exp_w);
        end
        widx++; run++;
      end else if (gt_data === LS_WORD && gt_ctrl === K_CTRL) begin
        checks++;
        if (in_pl) begin
          errors++; $display("FAIL b2b_ls_in_line: got LS after %0d words expected 960 then IDLE", run);
        end
        in_pl = 1'b1; run = 0; ls_cnt++;
      end else if (in_pl) begin
        checks++;
        if (run != 960) begin
          errors++; $display("FAIL b2b_run: got %0d words expected 960", run);
        end
        in_pl = 1'b0;
      end
    end
    vif.vin_de = 1'b0;
    checks++;
    if (ls_cnt != 2 || in_pl || widx != 1920) begin
      errors++; $display("FAIL b2b_done: got ls=%0d words=%0d expected ls=2 words=1920", ls_cnt, widx);
    end
  endtask

  task automatic test_abort();
    int guard;
    logic [31:0] exp_w;
    vif.vin_vs = 1'b0; tick();
    width = 16'd1920;
    vif.vin_vs = 1'b1; tick();
    checks++;
    if (gt_data !== FS_WORD) begin
      errors++; $display("FAIL abort_fs0: got %h expected %h", gt_data, FS_WORD);
    end
    for (int i = 0; i < 1920; i++) begin
      vif.vin_de = 1'b1; vif.vin_data = 16'(i);
      if (i == 10) vif.vin_vs = 1'b0;
      tick();
    end
    vif.vin_de = 1'b0;
    guard = 0;
    while (gt_data === IDLE_WORD && guard < 8) begin
      tick(); guard++;
    end
    checks++;
    if (gt_data !== LS_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL abort_ls: got %h/%b expected %h/%b", gt_data, gt_ctrl, LS_WORD, K_CTRL);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      exp_w = {16'(2*k+1), 16'(2*k)};
      checks++;
      if (gt_data !== exp_w || gt_ctrl !== D_CTRL) begin
        errors++; $display("FAIL abort_word[%0d]: got %h/%b expected %h/%b", k, gt_data, gt_ctrl, exp_w, D_CTRL);
      end
    end
    vif.vin_vs = 1'b1;
    tick();
    checks++;
    if (gt_data !== FS_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL abort_fs: got %h/%b expected %h/%b", gt_data, gt_ctrl, FS_WORD, K_CTRL);
    end
    checks++;
    if (dut.u_fifo.count !== 16'd0) begin
      errors++; $display("FAIL abort_flush: got %0d expected 0", dut.u_fifo.count);
    end
    for (int i = 0; i < 200; i++) begin
      tick();
      checks++;
      if (gt_data !== IDLE_WORD || gt_ctrl !== K_CTRL) begin
        errors++; $display("FAIL abort_quiet[%0d]: got %h/%b expected %h/%b", i, gt_data, gt_ctrl, IDLE_WORD, K_CTRL);
      end
    end
  endtask

  task automatic test_odd_burst();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h00020001; exp_w[1] = 32'h00040003; exp_w[2] = 32'h00000005;
    vif.vin_vs = 1'b0; tick();
    width = 16'd6;
    vif.vin_vs = 1'b1; tick();
    repeat (140) tick();
    for (int i = 1; i <= 6; i++) begin
      vif.vin_de   = (i <= 5);
      vif.vin_data = (i <= 5) ? 16'(i) : 16'hdead;
      tick();
      checks++;
      if (gt_data !== IDLE_WORD || gt_ctrl !== K_CTRL) begin
        errors++; $display("FAIL burst_hold[%0d]: got %h/%b expected %h/%b", i, gt_data, gt_ctrl, IDLE_WORD, K_CTRL);
      end
    end
    vif.vin_de = 1'b0;
    checks++;
    if (dut.u_fifo.count !== 16'd3) begin
      errors++; $display("FAIL burst_count: got %0d expected 3", dut.u_fifo.count);
    end
    tick();
    checks++;
    if (gt_data !== LS_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL burst_ls: got %h/%b expected %h/%b", gt_data, gt_ctrl, LS_WORD, K_CTRL);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (gt_data !== exp_w[k] || gt_ctrl !== D_CTRL) begin
        errors++; $display("FAIL burst_word[%0d]: got %h/%b expected %h/%b", k, gt_data, gt_ctrl, exp_w[k], D_CTRL);
      end
    end
    tick();
    checks++;
    if (gt_data !== IDLE_WORD || gt_ctrl !== K_CTRL) begin
      errors++; $display("FAIL burst_tail: got %h/%b expected %h/%b", gt_data, gt_ctrl, IDLE_WORD, K_CTRL);
    end
  endtask

  task automatic test_overflow();
    logic exp_o;
    width16 = 16'd80;
    vif16.vin_vs = 1'b1; tick();
    checks++;
    if (gt16_data !== FS_WORD) begin
      errors++; $display("FAIL ovf_fs: got %h expected %h", gt16_data, FS_WORD);
    end
    for (int i = 1; i <= 80; i++) begin
      vif16.vin_de = 1'b1; vif16.vin_data = 16'(i);
      tick();
      exp_o = (i >= 34);
      checks++;
      if (ovf16 !== exp_o) begin
        errors++; $display("FAIL ovf_pixel[%0d]: got %b expected %b", i, ovf16, exp_o);
      end
    end
    vif16.vin_de = 1'b0;
    repeat (5) tick();
    checks++;
    if (ovf16 !== 1'b1 || gt16_ctrl !== K_CTRL || gt16_data !== IDLE_WORD) begin
      errors++; $display("FAIL ovf_sticky: got ovf=%b %h/%b expected ovf=1 %h/%b", ovf16, gt16_data, gt16_ctrl, IDLE_WORD, K_CTRL);
    end
    vif16.vin_vs = 1'b0; tick();
    checks++;
    if (ovf16 !== 1'b1) begin
      errors++; $display("FAIL ovf_vs_fall: got %b expected 1", ovf16);
    end
    vif16.vin_vs = 1'b1; tick();
    checks++;
    if (ovf16 !== 1'b0 || gt16_data !== FS_WORD) begin
      errors++; $display("FAIL ovf_clear: got ovf=%b %h expected ovf=0 %h", ovf16, gt16_data, FS_WORD);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++; $display("FAIL main_no_ovf: got %b expected 0", ovf);
    end
  endtask

  initial begin
    test_reset();
    test_frame_line8();
    test_back_to_back();
    test_abort();
    test_odd_burst();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
